opb_master_arbiter: RTL and testbench

- Shares one OPB slave bus (e.g. the simulink2ppc/ppc2simulink register slaves) between up to 4 on-chip masters.
- Round-robin arbitration, one transaction per grant, with a bus-timeout watchdog.
- Sits between the user-side masters and the OPB slave wrappers, all on OPB_Clk.
- Returns read data and a per-master completion status: xferAck, retry or errAck.

---
 rtl/opb_arb_pkg.sv | 7 +
 rtl/opb_master_arbiter_rr_select.sv | 20 ++
 rtl/opb_master_arbiter.sv | 121 ++++++++++++
 tb/tb_opb_master_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/opb_arb_pkg.sv
// opb_arb_pkg: shared FSM/status encodings and OPB width constants for the master arbiter
package opb_arb_pkg;
  localparam int OPB_AW = 32;
  localparam int OPB_DW = 32;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
  typedef enum logic [1:0] {ST_ACK, ST_RETRY, ST_ERR, ST_ACK_ERR} status_e;
endpackage

// File: rtl/opb_master_arbiter_rr_select.sv
// rr_select: combinational round-robin picker, first requester at or after ptr_i
module rr_select #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int k = N - 1; k >= 0; k--)
      if (req_i[(int'(ptr_i) + k) % N]) begin
        idx_o   = IW'((int'(ptr_i) + k) % N);
        valid_o = 1'b1;
      end
  end
endmodule

// File: rtl/opb_master_arbiter.sv
// opb_master_arbiter: round-robin sharing of one OPB slave bus among N masters,
// one transaction per grant, with a select-timeout watchdog.
module opb_master_arbiter
  import opb_arb_pkg::*;
#(
  parameter int N_MASTERS    = 2,
  parameter int TOUT_CYCLES  = 16,
  parameter int C_OPB_AWIDTH = OPB_AW,
  parameter int C_OPB_DWIDTH = OPB_DW
) (
  input  logic                               OPB_Clk,
  input  logic                               OPB_Rst,
  input  logic [N_MASTERS-1:0]               M_request,
  input  logic [N_MASTERS*C_OPB_AWIDTH-1:0]  M_ABus,
  input  logic [N_MASTERS*C_OPB_DWIDTH/8-1:0] M_BE,
  input  logic [N_MASTERS*C_OPB_DWIDTH-1:0]  M_DBus,
  input  logic [N_MASTERS-1:0]               M_RNW,
  output logic [N_MASTERS-1:0]               M_grant,
  output logic [N_MASTERS-1:0]               M_xferAck,
  output logic [N_MASTERS-1:0]               M_retry,
  output logic [N_MASTERS-1:0]               M_errAck,
  output logic [C_OPB_DWIDTH-1:0]            M_rdData,
  output logic                               OPB_select,
  output logic [C_OPB_AWIDTH-1:0]            OPB_ABus,
  output logic [C_OPB_DWIDTH/8-1:0]          OPB_BE,
  output logic [C_OPB_DWIDTH-1:0]            OPB_DBus,
  output logic                               OPB_RNW,
  output logic                               OPB_seqAddr,
  input  logic [C_OPB_DWIDTH-1:0]            Sl_DBus,
  input  logic                               Sl_xferAck,
  input  logic                               Sl_retry,
  input  logic                               Sl_errAck,
  input  logic                               Sl_toutSup
);
  localparam int IW = N_MASTERS > 1 ? $clog2(N_MASTERS) : 1;
  localparam int BW = C_OPB_DWIDTH / 8;
  state_e                  state_q;
  status_e                 status_d;
  logic [IW-1:0]           ptr_q, idx_q, pick;
  logic                    valid, tout, fin;
  logic [7:0]              cnt_q;
  logic [N_MASTERS-1:0]    grant_q, ack_q, rty_q, err_q;
  logic [C_OPB_DWIDTH-1:0] rd_q, dbus_q;
  logic [C_OPB_AWIDTH-1:0] abus_q;
  logic [BW-1:0]           be_q;
  logic                    sel_q, rnw_q;
  rr_select #(.N(N_MASTERS), .IW(IW)) u_rr (
    .req_i(M_request), .ptr_i(ptr_q), .idx_o(pick), .valid_o(valid)
  );
  // A suppressed cycle neither counts nor can time out.
  assign tout     = cnt_q == 8'(TOUT_CYCLES - 1) && !Sl_toutSup;
  assign fin      = Sl_xferAck || Sl_retry || tout;
  assign status_d = Sl_xferAck ? (Sl_errAck ? ST_ACK_ERR : ST_ACK) : Sl_retry ? ST_RETRY : ST_ERR;
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      rty_q   <= '0;
      err_q   <= '0;
      rd_q    <= '0;
      sel_q   <= 1'b0;
      abus_q  <= '0;
      be_q    <= '0;
      dbus_q  <= '0;
      rnw_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (valid) begin
          state_q       <= S_BUSY;
          idx_q         <= pick;
          sel_q         <= 1'b1;
          grant_q       <= '0;
          grant_q[pick] <= 1'b1;
          abus_q        <= M_ABus[int'(pick)*C_OPB_AWIDTH +: C_OPB_AWIDTH];
          be_q          <= M_BE[int'(pick)*BW +: BW];
          rnw_q         <= M_RNW[pick];
          dbus_q        <= M_RNW[pick] ? '0 : M_DBus[int'(pick)*C_OPB_DWIDTH +: C_OPB_DWIDTH];
        end
        S_BUSY: if (fin) begin
          state_q      <= S_DONE;
          sel_q        <= 1'b0;
          abus_q       <= '0;
          be_q         <= '0;
          dbus_q       <= '0;
          rnw_q        <= 1'b0;
          rd_q         <= (Sl_xferAck && rnw_q) ? Sl_DBus : '0;
          ack_q[idx_q] <= status_d inside {ST_ACK, ST_ACK_ERR};
          rty_q[idx_q] <= status_d == ST_RETRY;
          err_q[idx_q] <= status_d inside {ST_ERR, ST_ACK_ERR};
        end else begin
          cnt_q <= Sl_toutSup ? cnt_q : cnt_q + 8'd1;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          grant_q <= '0;
          ack_q   <= '0;
          rty_q   <= '0;
          err_q   <= '0;
          cnt_q   <= '0;
          ptr_q   <= idx_q == IW'(N_MASTERS - 1) ? '0 : idx_q + 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign M_grant     = grant_q;
  assign M_xferAck   = ack_q;
  assign M_retry     = rty_q;
  assign M_errAck    = err_q;
  assign M_rdData    = rd_q;
  assign OPB_select  = sel_q;
  assign OPB_ABus    = abus_q;
  assign OPB_BE      = be_q;
  assign OPB_DBus    = dbus_q;
  assign OPB_RNW     = rnw_q;
  assign OPB_seqAddr = 1'b0;
endmodule

// File: tb/tb_opb_master_arbiter.sv
// tb_opb_master_arbiter: randomized scenarios checked against a transaction-level model
module tb_opb_master_arbiter;
  localparam int N = 2;
  localparam int T = 16;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  logic [N-1:0]    M_request, M_RNW, M_grant, M_xferAck, M_retry, M_errAck;
  logic [N*32-1:0] M_ABus, M_DBus;
  logic [N*4-1:0]  M_BE;
  logic [31:0]     M_rdData, OPB_ABus, OPB_DBus, Sl_DBus;
  logic [3:0]      OPB_BE;
  logic            OPB_select, OPB_RNW, OPB_seqAddr;
  logic            Sl_xferAck, Sl_retry, Sl_errAck, Sl_toutSup;
  logic [31:0] ma[N], md[N];
  logic [3:0]  mbe[N];
  logic        mr[N];
  logic [N-1:0] req;
  int nvec = 0, nerr = 0, ptr = 0;
  int pre_low, sup_len, rk;
  bit use_fix = 0;
  logic [31:0] dfix;
  opb_master_arbiter #(.N_MASTERS(N), .TOUT_CYCLES(T)) dut (
    .OPB_Clk(clk), .OPB_Rst(rst), .M_request(M_request), .M_ABus(M_ABus), .M_BE(M_BE),
    .M_DBus(M_DBus), .M_RNW(M_RNW), .M_grant(M_grant), .M_xferAck(M_xferAck),
    .M_retry(M_retry), .M_errAck(M_errAck), .M_rdData(M_rdData), .OPB_select(OPB_select),
    .OPB_ABus(OPB_ABus), .OPB_BE(OPB_BE), .OPB_DBus(OPB_DBus), .OPB_RNW(OPB_RNW),
    .OPB_seqAddr(OPB_seqAddr), .Sl_DBus(Sl_DBus), .Sl_xferAck(Sl_xferAck),
    .Sl_retry(Sl_retry), .Sl_errAck(Sl_errAck), .Sl_toutSup(Sl_toutSup)
  );
  always_comb begin
    M_ABus = '0; M_DBus = '0; M_BE = '0; M_RNW = '0;
    for (int i = 0; i < N; i++) begin
      M_ABus[i*32 +: 32] = ma[i];
      M_DBus[i*32 +: 32] = md[i];
      M_BE[i*4 +: 4]     = mbe[i];
      M_RNW[i]           = mr[i];
    end
  end
  assign M_request = req;
  function automatic logic [3:0] slave_in(int c); // {ack, retry, errAck, toutSup}
    if (c <= pre_low) return 4'b0000;
    if (c <= pre_low + sup_len) return 4'b0001;
    if (c == pre_low + sup_len + 1)
      case (rk)
        1: return 4'b1000;
        2: return 4'b0100;
        3: return 4'b1010;
        5: return 4'b1100;
        default: return 4'b0000;
      endcase
    return 4'b0000;
  endfunction
  task automatic new_fields(input int i);
    ma[i] = $urandom; md[i] = $urandom; mbe[i] = 4'($urandom); mr[i] = 1'($urandom);
  endtask
  task automatic drive_slave(input logic [3:0] s);
    {Sl_xferAck, Sl_retry, Sl_errAck, Sl_toutSup} = s;
    Sl_DBus = use_fix ? dfix : $urandom;
  endtask
  // Serves one transaction: model picks winner and outcome, bench plays the slave.
  task automatic run_txn(input bit keep, input bit drop);
    int w, win, c, lows, exp_len;
    bit e_ack, e_rty, e_err;
    logic [31:0] ea, ed, erd, rd;
    logic [3:0] eb, s;
    logic er;
    logic [N-1:0] eg;
    win = -1;
    for (int k = N - 1; k >= 0; k--) if (req[(ptr + k) % N]) win = (ptr + k) % N;
    lows = 0; exp_len = 0; e_ack = 0; e_rty = 0; e_err = 0;
    for (int cc = 1; cc <= 1000 && exp_len == 0; cc++) begin
      s = slave_in(cc);
      if (s[3]) begin exp_len = cc; e_ack = 1; e_err = s[1]; end
      else if (s[2]) begin exp_len = cc; e_rty = 1; end
      else if (!s[0]) begin lows++; if (lows == T) begin exp_len = cc; e_err = 1; end end
    end
    w = 0;
    do begin @(negedge clk); w++; end while (!OPB_select && w < 20);
    nvec++;
    if (w != 1 || !OPB_select || win < 0) begin
      nerr++; $display("FAIL latency: select seen after %0d cycles (select=%b), required 1", w, OPB_select);
      return;
    end
    eg = '0; eg[win] = 1'b1;
    ea = ma[win]; eb = mbe[win]; er = mr[win]; ed = er ? 32'h0 : md[win];
    nvec++;
    if ({M_grant, OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW} !== {eg, ea, eb, ed, er}) begin
      nerr++; $display("FAIL grant_bus: got g=%b a=%h be=%h d=%h rnw=%b, required g=%b a=%h be=%h d=%h rnw=%b",
        M_grant, OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, eg, ea, eb, ed, er);
    end
    new_fields(win);
    if (drop) req[win] = 1'b0;
    c = 1; s = slave_in(1); drive_slave(s); rd = Sl_DBus;
    forever begin
      @(negedge clk);
      if (!OPB_select || c >= 1000) break;
      nvec++;
      if (M_grant !== eg || OPB_ABus !== ea || OPB_RNW !== er) begin
        nerr++; $display("FAIL hold: cycle %0d g=%b a=%h rnw=%b, required g=%b a=%h rnw=%b", c, M_grant, OPB_ABus, OPB_RNW, eg, ea, er);
      end
      c++; s = slave_in(c); drive_slave(s);
      if (s[3]) rd = Sl_DBus;
    end
    drive_slave(4'b0000);
    erd = (e_ack && er) ? rd : 32'h0;
    nvec++;
    if (c != exp_len) begin nerr++; $display("FAIL busy_len: select high %0d cycles, required %0d", c, exp_len); end
    nvec++;
    if ({M_xferAck, M_retry, M_errAck} !== {{N{e_ack}} & eg, {N{e_rty}} & eg, {N{e_err}} & eg}) begin
      nerr++; $display("FAIL pulse: ack=%b rty=%b err=%b, required ack=%b rty=%b err=%b",
        M_xferAck, M_retry, M_errAck, {N{e_ack}} & eg, {N{e_rty}} & eg, {N{e_err}} & eg);
    end
    nvec++;
    if ({M_grant, OPB_select, OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW} !== {eg, 70'h0}) begin
      nerr++; $display("FAIL done_bus: g=%b sel=%b a=%h be=%h d=%h rnw=%b, required g=%b and bus 0",
        M_grant, OPB_select, OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, eg);
    end
    if (e_ack) begin
      nvec++;
      if (M_rdData !== erd) begin nerr++; $display("FAIL rddata: got %h, required %h", M_rdData, erd); end
    end
    if (!drop) req[win] = keep;
    ptr = (win + 1) % N;
    @(negedge clk);
    nvec++;
    if ({M_xferAck, M_retry, M_errAck, M_grant, OPB_select} !== '0) begin
      nerr++; $display("FAIL idle_gap: ack=%b rty=%b err=%b g=%b sel=%b, required all 0", M_xferAck, M_retry, M_errAck, M_grant, OPB_select);
    end
  endtask
  task automatic sched(input int p, input int s, input int r);
    pre_low = p; sup_len = s; rk = r;
  endtask
  task automatic test_reset;
    rst = 1; req = '0; drive_slave(4'b0000);
    for (int i = 0; i < N; i++) new_fields(i);
    repeat (3) @(negedge clk);
    nvec++;
    if ({M_grant, M_xferAck, M_retry, M_errAck, M_rdData, OPB_select, OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_seqAddr} !== '0) begin
      nerr++; $display("FAIL reset: outputs not all 0 (g=%b sel=%b a=%h)", M_grant, OPB_select, OPB_ABus);
    end
    rst = 0; ptr = 0;
  endtask
  task automatic test_single_read;
    req = 2'b01; ma[0] = 32'h0100_0300; mr[0] = 1'b1;
    use_fix = 1; dfix = 32'hDEAD_BEEF;
    sched(2, 0, 1); run_txn(0, 0);
    use_fix = 0;
  endtask
  task automatic test_round_robin;
    req = 2'b11;
    for (int i = 0; i < 8; i++) begin sched(0, 0, 1); run_txn(1, 0); end
  endtask
  task automatic test_timeout;
    req = 2'b11;
    sched(0, 0, 0); run_txn(1, 0);
    sched(0, 0, 1); run_txn(0, 0);
  endtask
  task automatic test_tout_sup;
    req = 2'b11;
    sched(3, 40, 1); run_txn(1, 0);
    sched(10, 40, 0); run_txn(1, 0);
  endtask
  task automatic test_retry_ackerr;
    req = 2'b11;
    sched(0, 0, 2); run_txn(1, 0);
    sched(1, 0, 3); run_txn(1, 0);
    sched(0, 2, 5); run_txn(1, 0);
    sched(0, 0, 2); run_txn(1, 1);
  endtask
  task automatic test_random;
    for (int i = 0; i < 25; i++) begin
      if (req == '0) req = N'($urandom_range(1, (1 << N) - 1));
      sched($urandom_range(0, 6), $urandom_range(0, 20), $urandom_range(0, 5));
      run_txn(1'($urandom), $urandom_range(0, 3) == 0);
    end
  endtask
  task automatic test_reset_mid;
    int w;
    req = 2'b01; sched(0, 0, 1); run_txn(0, 0);
    req = 2'b11; drive_slave(4'b0000);
    w = 0;
    do begin @(negedge clk); w++; end while (!OPB_select && w < 20);
    nvec++;
    if (M_grant !== 2'b10) begin nerr++; $display("FAIL mid_grant: got %b, required 10", M_grant); end
    repeat (2) @(negedge clk);
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      nvec++;
      if ({M_grant, M_xferAck, M_retry, M_errAck, M_rdData, OPB_select, OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW} !== '0) begin
        nerr++; $display("FAIL mid_reset: g=%b ack=%b rty=%b err=%b sel=%b, required all 0", M_grant, M_xferAck, M_retry, M_errAck, OPB_select);
      end
    end
    rst = 0; ptr = 0;
    sched(0, 0, 1); run_txn(0, 0);
    req = '0;
  endtask
  initial begin
    test_reset;
    test_single_read;
    test_round_robin;
    test_timeout;
    test_tout_sup;
    test_retry_ackerr;
    test_random;
    test_reset_mid;
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
